hamming_scan_decoder: RTL

// - Multi-channel Hamming(7,4) single-error-correcting decoder with a time-multiplexed 7-segment display.
// - Captures DIGITS codewords on a strobe and registers the corrected nibbles and syndromes.
// - Counts corrected words and scans one channel per display digit.
// - Sits between the switch/serial input front end and the board's anode/cathode pins.

---
 rtl/hamming_pkg.sv | 21 ++
 rtl/hamming74_dec.sv | 24 ++
 rtl/hamming_scan_decoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types, 7-segment table and helpers for the Hamming scan decoder
package hamming_pkg;

  typedef logic [2:0] syndrome_t;

  typedef enum logic {
    DISP_DATA = 1'b0,
    DISP_SYND = 1'b1
  } disp_mode_t;

  // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/hamming74_dec.sv
// rtl/hamming74_dec.sv - combinational Hamming(7,4) single-error-correcting decoder
module hamming74_dec
  import hamming_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] data,
  output syndrome_t  syndrome
);

  logic [6:0] fixed;

  // code[i] is Hamming position i+1; a nonzero syndrome names the bit to flip
  always_comb begin
    syndrome[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
    syndrome[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
    syndrome[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
    fixed = code;
    if (syndrome != 3'd0) begin
      fixed = code ^ (7'b000_0001 << (syndrome - 3'd1));
    end
    data = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

endmodule

// File: rtl/hamming_scan_decoder.sv
// rtl/hamming_scan_decoder.sv - multi-channel Hamming(7,4) decoder with scanned 7-segment display
module hamming_scan_decoder
  import hamming_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS*7-1:0]   code_in,
  input  logic                  code_valid,
  input  logic                  mode,
  output logic [DIGITS*4-1:0]   data_out,
  output logic [DIGITS-1:0]     err_any,
  output logic                  valid_out,
  output logic [CNT_W-1:0]      err_count,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            cathode
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PS_W  = $clog2(REFRESH_DIV);
  localparam int POP_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [DIGITS*4-1:0] dec_data;
  syndrome_t           dec_syn [DIGITS];
  syndrome_t           syn_r   [DIGITS];
  logic [DIGITS-1:0]   new_err;
  logic [POP_W-1:0]    pop;
  logic [CNT_W:0]      sum;
  logic [CNT_W-1:0]    next_count;
  logic                display_en;
  logic [PS_W-1:0]     presc;
  logic [IDX_W-1:0]    idx;
  logic [DIGITS-1:0]   idx_onehot;
  logic [3:0]          cur_nibble;
  syndrome_t           cur_syn;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    hamming74_dec u_dec (
      .code     (code_in[7*k +: 7]),
      .data     (dec_data[4*k +: 4]),
      .syndrome (dec_syn[k])
    );
  end

  // Per-channel error flags and the saturating counter's next value
  always_comb begin
    pop = '0;
    for (int k = 0; k < DIGITS; k++) begin
      new_err[k] = |dec_syn[k];
      pop = pop + POP_W'(new_err[k]);
    end
    sum = {1'b0, err_count} + (CNT_W+1)'(pop);
    next_count = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  // Capture decoded words on the strobe; a strobe coincident with reset is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      err_any    <= '0;
      valid_out  <= 1'b0;
      err_count  <= '0;
      display_en <= 1'b0;
      for (int k = 0; k < DIGITS; k++) syn_r[k] <= '0;
    end else begin
      valid_out <= code_valid;
      if (code_valid) begin
        data_out   <= dec_data;
        err_any    <= new_err;
        err_count  <= next_count;
        display_en <= 1'b1;
        for (int k = 0; k < DIGITS; k++) syn_r[k] <= dec_syn[k];
      end
    end
  end

  // Prescaler and digit index keep running even while the display is blank
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PS_W'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Select the channel currently being scanned
  always_comb begin
    idx_onehot = '0;
    cur_nibble = '0;
    cur_syn    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        idx_onehot[k] = 1'b1;
        cur_nibble    = data_out[4*k +: 4];
        cur_syn       = syn_r[k];
      end
    end
  end

  // Registered anode/cathode drive, blank until the first decoded word arrives
  always_ff @(posedge clk) begin
    if (reset || !display_en) begin
      an      <= '1;
      cathode <= 7'h7F;
    end else begin
      an      <= ~idx_onehot;
      cathode <= (disp_mode_t'(mode) == DISP_SYND) ? seg({1'b0, cur_syn}) : seg(cur_nibble);
    end
  end

endmodule
